// File: rtl/button_led_pkg.sv
// Shared constants for button_led_ctrl: operating-mode encodings and counter sizing.
package button_led_pkg;

    localparam int MODE_DIRECT = 0;
    localparam int MODE_TOGGLE = 1;

    // Width of a counter that must be able to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, hold-time debounce and press-edge pulse.
module button_debounce
    import button_led_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic stable,
    output logic press
);

    localparam int               CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        sync1_d  = inp;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // The count only survives while every synced sample disagrees with stable.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                press_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/button_led_ctrl.sv
// N-channel debounced button to red/blue LED controller, direct or toggle mode.
// Optional blinking of the blue LEDs is enabled by defining BUTTON_LED_BLINK_EN.
module button_led_ctrl
    import button_led_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DB_CYCLES  = 50000,
    parameter int TOGGLE     = 0,
    parameter int BLINK_HALF = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] inp,
    output logic [N_CH-1:0] red_led,
    output logic [N_CH-1:0] blue_led,
    output logic [N_CH-1:0] press
);

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] active;
    logic [N_CH-1:0] blink_mask;
    logic [N_CH-1:0] active_q, active_d;
    logic [N_CH-1:0] red_q, red_d;
    logic [N_CH-1:0] blue_q, blue_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .inp   (inp[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

`ifdef BUTTON_LED_BLINK_EN
    localparam int               PRE_W    = cnt_width(BLINK_HALF);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             phase_q, phase_d;

    always_comb begin
        pre_d   = pre_q + 1'b1;
        phase_d = phase_q;
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end

    assign blink_mask = {N_CH{phase_q}};
`else
    logic unused_blink_half;
    assign unused_blink_half = |BLINK_HALF;
    assign blink_mask        = '1;
`endif

    always_comb begin
        active   = (TOGGLE == MODE_TOGGLE) ? active_q : stable;
        active_d = active_q ^ press;
        red_d    = active;
        blue_d   = ~active & blink_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            red_q    <= '0;
            blue_q   <= '1;
        end else begin
            active_q <= active_d;
            red_q    <= red_d;
            blue_q   <= blue_d;
        end
    end

    assign red_led  = red_q;
    assign blue_led = blue_q;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Bench for button_led_ctrl: direct and toggle instances share inputs and are checked
// against a rule-level reference model; blink checks follow BUTTON_LED_BLINK_EN.
module tb_button_led_ctrl;

    localparam int DB = 4;
    localparam int BH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] inp = 2'b00;
    logic [1:0] red_dir, blue_dir, press_dir;
    logic [1:0] red_tog, blue_tog, press_tog;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    button_led_ctrl #(
        .N_CH(2), .DB_CYCLES(DB), .TOGGLE(0), .BLINK_HALF(BH)
    ) dut_direct (
        .clk(clk), .rst(rst), .inp(inp),
        .red_led(red_dir), .blue_led(blue_dir), .press(press_dir)
    );

    button_led_ctrl #(
        .N_CH(2), .DB_CYCLES(DB), .TOGGLE(1), .BLINK_HALF(BH)
    ) dut_toggle (
        .clk(clk), .rst(rst), .inp(inp),
        .red_led(red_tog), .blue_led(blue_tog), .press(press_tog)
    );

    // Reference model: inputs reach the debouncer two edges late; stable flips once the
    // last DB synced samples all disagree with it.
    logic [1:0] dly[$];
    logic [1:0] hist[$];
    logic [1:0] m_stable, m_press, m_tact;
    int         m_edges;
    logic [1:0] e_red_dir, e_blue_dir, e_red_tog, e_blue_tog, e_press;

    task automatic tick();
        logic [1:0] synced, flip, new_stable;
        logic       phase;
        @(posedge clk);
        if (rst) begin
            dly.delete();
            dly.push_back(2'b00);
            dly.push_back(2'b00);
            hist.delete();
            m_stable   = '0;
            m_press    = '0;
            m_tact     = '0;
            m_edges    = 0;
            e_red_dir  = '0;
            e_red_tog  = '0;
            e_blue_dir = '1;
            e_blue_tog = '1;
            e_press    = '0;
        end else begin
            synced = dly.pop_front();
            dly.push_back(inp);
            hist.push_back(synced);
            if (hist.size() > DB) void'(hist.pop_front());
`ifdef BUTTON_LED_BLINK_EN
            phase = ((m_edges / BH) % 2) == 0;
`else
            phase = 1'b1;
`endif
            e_red_dir  = m_stable;
            e_blue_dir = ~m_stable & {2{phase}};
            e_red_tog  = m_tact;
            e_blue_tog = ~m_tact & {2{phase}};
            flip = '0;
            if (hist.size() == DB) begin
                flip = '1;
                foreach (hist[j]) flip &= hist[j] ^ m_stable;
            end
            new_stable = m_stable ^ flip;
            m_tact     = m_tact ^ m_press;
            e_press    = new_stable & ~m_stable;
            m_press    = e_press;
            m_stable   = new_stable;
            m_edges++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        inp = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inp = 2'($urandom);
        repeat (3) tick();
        vectors += 6;
        if (red_dir !== 2'b00) begin miscompares++; $display("FAIL reset_red_dir: got %b expected 00", red_dir); end
        if (blue_dir !== 2'b11) begin miscompares++; $display("FAIL reset_blue_dir: got %b expected 11", blue_dir); end
        if (press_dir !== 2'b00) begin miscompares++; $display("FAIL reset_press_dir: got %b expected 00", press_dir); end
        if (red_tog !== 2'b00) begin miscompares++; $display("FAIL reset_red_tog: got %b expected 00", red_tog); end
        if (blue_tog !== 2'b11) begin miscompares++; $display("FAIL reset_blue_tog: got %b expected 11", blue_tog); end
        if (press_tog !== 2'b00) begin miscompares++; $display("FAIL reset_press_tog: got %b expected 00", press_tog); end
        rst = 1'b0;
        inp = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_direct_press();
        int rise_d = -1, rise_t = -1, fall_d = -1, pulses = 0;
        inp[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (red_dir[0] && rise_d < 0) rise_d = i;
            if (red_tog[0] && rise_t < 0) rise_t = i;
            if (press_dir[0]) pulses++;
        end
        vectors += 4;
        if (rise_d != 7) begin miscompares++; $display("FAIL direct_rise_latency: got %0d expected 7", rise_d); end
        if (rise_t != 8) begin miscompares++; $display("FAIL toggle_rise_latency: got %0d expected 8", rise_t); end
        if (pulses != 1) begin miscompares++; $display("FAIL press_pulse_count: got %0d expected 1", pulses); end
        if (blue_dir[0] !== 1'b0) begin miscompares++; $display("FAIL pressed_blue: got %b expected 0", blue_dir[0]); end
        inp[0] = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!red_dir[0] && fall_d < 0) fall_d = i;
            if (press_dir[0] || press_tog[0]) pulses++;
        end
        vectors += 4;
        if (fall_d != 7) begin miscompares++; $display("FAIL direct_fall_latency: got %0d expected 7", fall_d); end
        if (pulses != 0) begin miscompares++; $display("FAIL release_pulse_count: got %0d expected 0", pulses); end
        if (red_tog[0] !== 1'b1) begin miscompares++; $display("FAIL toggle_hold: got %b expected 1", red_tog[0]); end
        if (blue_dir !== e_blue_dir) begin miscompares++; $display("FAIL released_blue: got %b expected %b", blue_dir, e_blue_dir); end
    endtask

    task automatic test_glitch();
        logic [1:0] red_d0, red_t0;
        int changed = 0, pulses = 0, blue_bad = 0;
        red_d0 = red_dir;
        red_t0 = red_tog;
        for (int i = 1; i <= 15; i++) begin
            inp[1] = (i <= 3);
            tick();
            if (red_dir !== red_d0 || red_tog !== red_t0) changed++;
            if ((press_dir | press_tog) != 2'b00) pulses++;
            if (blue_dir !== e_blue_dir || blue_tog !== e_blue_tog) blue_bad++;
        end
        vectors += 3;
        if (changed != 0) begin miscompares++; $display("FAIL glitch_red: got %0d changed cycles expected 0", changed); end
        if (pulses != 0) begin miscompares++; $display("FAIL glitch_press: got %0d pulse cycles expected 0", pulses); end
        if (blue_bad != 0) begin miscompares++; $display("FAIL glitch_blue: got %0d bad cycles expected 0", blue_bad); end
    endtask

    task automatic test_toggle();
        logic red_after[2];
        int pulses = 0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 24; i++) begin
                inp[0] = (i < 12);
                tick();
                if (press_tog[0]) pulses++;
            end
            red_after[p] = red_tog[0];
        end
        vectors += 3;
        if (red_after[0] !== 1'b1) begin miscompares++; $display("FAIL toggle_first: got %b expected 1", red_after[0]); end
        if (red_after[1] !== 1'b0) begin miscompares++; $display("FAIL toggle_second: got %b expected 0", red_after[1]); end
        if (pulses != 2) begin miscompares++; $display("FAIL toggle_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_simultaneous_reset();
        logic [1:0] first_val = 2'b00, tog_val = 2'b00;
        int first = -1, tog_first = -1, early = 0, rise = -1, pulses = 0;
        do_reset();
        inp = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (red_dir != 2'b00 && first < 0) begin first = i; first_val = red_dir; end
            if (red_tog != 2'b00 && tog_first < 0) begin tog_first = i; tog_val = red_tog; end
        end
        vectors += 3;
        if (first != 7) begin miscompares++; $display("FAIL simul_latency: got %0d expected 7", first); end
        if (first_val !== 2'b11) begin miscompares++; $display("FAIL simul_direct_both: got %b expected 11", first_val); end
        if (tog_val !== 2'b11) begin miscompares++; $display("FAIL simul_toggle_both: got %b expected 11", tog_val); end
        do_reset();
        inp = 2'b11;
        repeat (4) begin
            tick();
            if (red_dir != 2'b00 || press_dir != 2'b00) early++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (red_dir != 2'b00 && rise < 0) rise = i;
            if (press_tog[0]) pulses++;
        end
        vectors += 3;
        if (early != 0) begin miscompares++; $display("FAIL mid_debounce_change: got %0d cycles expected 0", early); end
        if (rise != 7) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 7", rise); end
        if (pulses != 1) begin miscompares++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses); end
        inp = 2'b00;
        repeat (12) tick();
    endtask

    task automatic test_blink();
        logic [1:0] exp_blue;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inp = 2'b00;
        for (int i = 1; i <= 12; i++) begin
            tick();
`ifdef BUTTON_LED_BLINK_EN
            exp_blue = ((((i - 1) / BH) % 2) == 0) ? 2'b11 : 2'b00;
`else
            exp_blue = 2'b11;
`endif
            vectors++;
            if (blue_dir !== exp_blue) begin
                miscompares++;
                $display("FAIL blink_blue cycle %0d: got %b expected %b", i, blue_dir, exp_blue);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                inp  = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 8);
            end
            hold--;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            vectors += 6;
            if (red_dir !== e_red_dir) begin miscompares++; $display("FAIL rand_red_dir @%0d: got %b expected %b", c, red_dir, e_red_dir); end
            if (blue_dir !== e_blue_dir) begin miscompares++; $display("FAIL rand_blue_dir @%0d: got %b expected %b", c, blue_dir, e_blue_dir); end
            if (red_tog !== e_red_tog) begin miscompares++; $display("FAIL rand_red_tog @%0d: got %b expected %b", c, red_tog, e_red_tog); end
            if (blue_tog !== e_blue_tog) begin miscompares++; $display("FAIL rand_blue_tog @%0d: got %b expected %b", c, blue_tog, e_blue_tog); end
            if (press_dir !== e_press || press_tog !== e_press) begin
                miscompares++;
                $display("FAIL rand_press @%0d: got %b/%b expected %b", c, press_dir, press_tog, e_press);
            end
            if (((red_dir & blue_dir) | (red_tog & blue_tog)) != 2'b00) begin
                miscompares++;
                $display("FAIL rand_exclusive @%0d: got red %b blue %b", c, red_dir, blue_dir);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_direct_press();
        test_glitch();
        test_toggle();
        test_simultaneous_reset();
        test_blink();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_led_ctrl.md
BUTTON_LED_CTRL -- requirements
Module: button_led_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent button/LED channels (1..16).
REQ-002 SHALL have parameter DB_CYCLES, default 50000, consecutive clock cycles an input must hold a new level before it is accepted (>=1).
REQ-003 SHALL have parameter TOGGLE, default 0: 0 = direct mode, 1 = toggle mode.
REQ-004 SHALL have parameter BLINK_HALF, default 12500000, blink half-period in clocks (used only under REQ-021).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port inp, input, N_CH bits: raw asynchronous push buttons, 1 = pressed.
REQ-008 SHALL have port red_led, output, N_CH bits: 1 = channel active.
REQ-009 SHALL have port blue_led, output, N_CH bits: 1 = channel inactive.
REQ-010 SHALL have port press, output, N_CH bits: one-cycle pulse on each accepted press.

Function
REQ-011 SHALL synchronise each inp bit through two flip-flops before any other use.
REQ-012 Per channel, SHALL hold a debounced level `stable` and a counter of width $clog2(DB_CYCLES+1).
- Synced sample == stable: counter cleared.
- Synced sample != stable: counter increments.
- On the cycle the counter reaches DB_CYCLES-1 with a differing sample: stable flips and the counter clears.
REQ-013 A glitch shorter than DB_CYCLES synced cycles SHALL leave stable unchanged and SHALL restart the count from zero on the next differing sample.
REQ-014 SHALL assert press[i] for exactly one cycle, registered, on the cycle after stable[i] rises 0->1; releases SHALL produce no pulse.
REQ-015 Direct mode: active[i] SHALL equal stable[i].
REQ-016 Toggle mode: active[i] SHALL invert on each press[i] pulse and hold otherwise.
REQ-017 red_led SHALL equal active and blue_led SHALL equal ~active, both registered.
- Direct-mode latency from a clean inp edge to the LED change: 2 + DB_CYCLES + 1 clocks.
- Toggle-mode latency from a clean inp edge to the LED change: 2 + DB_CYCLES + 2 clocks.
REQ-018 Channels SHALL be fully independent; simultaneous presses on any subset SHALL each be processed in the same cycle.
REQ-019 red_led[i] and blue_led[i] SHALL never both be 1, except as allowed by REQ-021.

Reset
REQ-020 While rst=1 at a clk edge, the following SHALL be set:
- synchroniser flops = 0, stable = 0, counters = 0, active = 0;
- press = 0, red_led = 0, blue_led = all 1s, blink prescaler = 0, blink phase = 1.
- A button held through reset release SHALL require a full debounce, and in toggle mode SHALL produce one press pulse.

Configuration
REQ-021 Macro BUTTON_LED_BLINK_EN:
- Defined: a shared prescaler SHALL count 0..BLINK_HALF-1 and flip a blink phase on wrap; blue_led[i] SHALL equal ~active[i] & phase.
- Undefined: no prescaler SHALL be present and blue_led SHALL be solid per REQ-017.

Structure
REQ-022 Package button_led_pkg SHALL hold the mode constants MODE_DIRECT=0 and MODE_TOGGLE=1, and the counter-width function.
REQ-023 Sub-module button_debounce SHALL implement one channel's synchroniser, debounce and press detect; it SHALL be instantiated N_CH times in a generate loop.

Verification
REQ-024 With N_CH=2 and DB_CYCLES=4, the bench SHALL cover these directed scenarios:
- Reset: rst high 3 cycles -> red_led=2'b00, blue_led=2'b11, press=2'b00.
- Direct clean press: inp[0] held high 20 cycles -> red_led[0] rises exactly 7 clocks after the inp edge, press[0] pulses once; releasing inp[0] drops red_led[0] 7 clocks later with no pulse.
- Glitch: inp[1] high 3 cycles then low -> red_led, blue_led and press unchanged.
- Toggle (TOGGLE=1): two clean presses on inp[0] -> red_led[0] 0->1->0, with 2 press pulses total.
- Simultaneous press plus mid-debounce reset: both inputs rise together -> both LEDs change on the same cycle; rst asserted 2 cycles into debounce -> no LED change, and a full 4-cycle debounce is required after release.
- Blink (BUTTON_LED_BLINK_EN, BLINK_HALF=3): idle -> blue_led toggles every 3 clocks, starting high.
